// File: rtl/bloom_pkg.sv
// Shared definitions for the Bloom filter controller: op codes, hash salts,
// state encoding and the key fold/index function.
package bloom_pkg;

    localparam logic [4:0] OP_INSERT = 5'b00001;
    localparam logic [4:0] OP_CLEAR  = 5'b00011;
    localparam logic [4:0] OP_CHECK  = 5'b00100;

    // SALT[i] is XORed into the folded key to form hash i.
    localparam logic [3:0][7:0] SALT = {8'h3C, 8'hA5, 8'h5A, 8'h00};

    typedef logic [2:0] state_t;
    localparam state_t IDLE = 3'd0;
    localparam state_t RD   = 3'd1;
    localparam state_t WR   = 3'd2;
    localparam state_t CHK  = 3'd3;
    localparam state_t CLR  = 3'd4;
    localparam state_t RESP = 3'd5;

    function automatic logic [7:0] key_fold(input logic [31:0] key);
        return key[31:24] ^ key[23:16] ^ key[15:8] ^ key[7:0];
    endfunction

    function automatic logic [7:0] bloom_index(input logic [31:0] key, input logic [1:0] hnum);
        return key_fold(key) ^ SALT[hnum];
    endfunction

endpackage

// File: rtl/bloom_ctrl_if.sv
// Request/response handshake between the instruction decode and bloom_ctrl.
interface bloom_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_match;
    logic        rsp_err;

    modport master (
        output req_valid, req_op, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_match, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_match, rsp_err
    );
endinterface

// File: rtl/bloom_hash.sv
// Combinational hash: maps (key, hash number) to a RAM word address and bit position.
module bloom_hash
    import bloom_pkg::*;
#(
    parameter int NUM_BITS = 256,
    localparam int NUM_WORDS = NUM_BITS / 32,
    localparam int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic [31:0]   key,
    input  logic [1:0]    hnum,
    output logic [AW-1:0] word,
    output logic [4:0]    bit_pos
);

    logic [7:0] idx;

    assign idx     = bloom_index(key, hnum) & 8'(NUM_BITS - 1);
    assign word    = AW'(idx >> 5);
    assign bit_pos = idx[4:0];

endmodule

// File: rtl/bloom_ctrl.sv
// Bloom filter sequencing controller: insert (read-modify-write), check
// (read-compare with early exit) and clear (full sweep) over an external sync RAM.
module bloom_ctrl
    import bloom_pkg::*;
#(
    parameter int NUM_BITS = 256,
    parameter int WORD_W   = 32,
    parameter int NUM_HASH = 3,
    localparam int NUM_WORDS = NUM_BITS / WORD_W,
    localparam int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    bloom_ctrl_if.slave       bus,
    output logic [15:0]       ins_count,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    localparam logic [1:0]    LAST_H = 2'(NUM_HASH - 1);
    localparam logic [AW-1:0] LAST_W = AW'(NUM_WORDS - 1);

    state_t        state;
    logic [4:0]    op;
    logic [31:0]   key;
    logic [1:0]    hcnt;
    logic [AW-1:0] ccnt;
    logic          match;
    logic          err;
    logic [AW-1:0] hword;
    logic [4:0]    hbit;

    bloom_hash #(.NUM_BITS(NUM_BITS)) u_hash (
        .key     (key),
        .hnum    (hcnt),
        .word    (hword),
        .bit_pos (hbit)
    );

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_match = match;
    assign bus.rsp_err   = err;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order. The RAM is external and
    // is never cleared by reset; only the clear op sweeps it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op        <= '0;
            key       <= '0;
            hcnt      <= '0;
            ccnt      <= '0;
            match     <= 1'b0;
            err       <= 1'b0;
            ins_count <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    op    <= bus.req_op;
                    key   <= bus.req_data;
                    hcnt  <= '0;
                    ccnt  <= '0;
                    match <= 1'b0;
                    err   <= 1'b0;
                    case (bus.req_op)
                        OP_INSERT, OP_CHECK: state <= RD;
                        OP_CLEAR:            state <= CLR;
                        default: begin
                            err   <= 1'b1;
                            state <= RESP;
                        end
                    endcase
                end
                RD: state <= (op == OP_INSERT) ? WR : CHK;
                WR: if (hcnt == LAST_H) begin
                    state <= RESP;
                    if (ins_count != 16'hFFFF) ins_count <= ins_count + 16'd1;
                end else begin
                    hcnt  <= hcnt + 2'd1;
                    state <= RD;
                end
                CHK: if (!mem_rdata[hbit]) begin
                    // Any clear bit proves absence; skip the remaining hashes.
                    match <= 1'b0;
                    state <= RESP;
                end else if (hcnt == LAST_H) begin
                    match <= 1'b1;
                    state <= RESP;
                end else begin
                    hcnt  <= hcnt + 2'd1;
                    state <= RD;
                end
                CLR: if (ccnt == LAST_W) begin
                    ins_count <= '0;
                    state     <= RESP;
                end else begin
                    ccnt <= ccnt + AW'(1);
                end
                RESP: if (bus.rsp_ready) begin
                    match <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            RD: mem_addr = hword;
            WR: begin
                // Address held from RD; rdata is the word read in RD.
                mem_addr  = hword;
                mem_we    = 1'b1;
                mem_wdata = mem_rdata | (WORD_W'(1) << hbit);
            end
            CLR: begin
                mem_addr = ccnt;
                mem_we   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bloom_ctrl.sv
// Directed bench for bloom_ctrl with a behavioural synchronous RAM and a write log.
module tb_bloom_ctrl;
    import bloom_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ins_count;
    logic [2:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        preload;

    int checks = 0;
    int failures = 0;

    logic [31:0] ram [8];
    logic [2:0]  wa [$];
    logic [31:0] wd [$];

    bloom_ctrl_if bus();

    bloom_ctrl #(.NUM_BITS(256), .WORD_W(32), .NUM_HASH(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ins_count (ins_count),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) ram[i] <= '0;
            mem_rdata <= '0;
        end else begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                wa.push_back(mem_addr);
                wd.push_back(mem_wdata);
            end
            mem_rdata <= ram[mem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one op, wait for rsp_valid (bounded), complete the handshake.
    // lat = cycles from the accept cycle to the first cycle rsp_valid is seen.
    task automatic do_op(input logic [4:0] op, input logic [31:0] data,
                         output int lat, output logic m, output logic e);
        @(negedge clk);
        wa.delete();
        wd.delete();
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_data  = data;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready: req_ready=%b required 1", bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        m = bus.rsp_match;
        e = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_handshake: rsp_valid=%b req_ready=%b required 0/1",
                     bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        preload = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        preload = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.rsp_match !== 1'b0 ||
            bus.rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: ready=%b valid=%b match=%b err=%b required 1/0/0/0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_match, bus.rsp_err);
        end
        checks++;
        if (ins_count !== 16'd0 || mem_we !== 1'b0 || mem_addr !== 3'd0 || mem_wdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_mem: ins_count=%h we=%b addr=%h wdata=%h required 0",
                     ins_count, mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_check_miss(input string tag);
        int lat;
        logic m, e;
        do_op(OP_CHECK, 32'h12345678, lat, m, e);
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL %s_latency: got %0d required 3", tag, lat);
        end
        checks++;
        if (m !== 1'b0 || e !== 1'b0) begin
            failures++;
            $display("FAIL %s_result: match=%b err=%b required 0/0", tag, m, e);
        end
        checks++;
        if (wa.size() != 0) begin
            failures++;
            $display("FAIL %s_writes: got %0d writes required 0", tag, wa.size());
        end
    endtask

    task automatic test_insert(input logic [31:0] key, input logic [31:0] exp_d [3],
                               input logic [15:0] exp_cnt);
        int lat;
        logic m, e;
        logic [2:0] exp_a [3];
        exp_a = '{3'd0, 3'd2, 3'd5};
        do_op(OP_INSERT, key, lat, m, e);
        checks++;
        if (lat !== 7) begin
            failures++;
            $display("FAIL insert_latency key=%h: got %0d required 7", key, lat);
        end
        checks++;
        if (m !== 1'b0 || e !== 1'b0) begin
            failures++;
            $display("FAIL insert_result key=%h: match=%b err=%b required 0/0", key, m, e);
        end
        checks++;
        if (ins_count !== exp_cnt) begin
            failures++;
            $display("FAIL insert_count key=%h: got %0d required %0d", key, ins_count, exp_cnt);
        end
        checks++;
        if (wa.size() != 3) begin
            failures++;
            $display("FAIL insert_nwrites key=%h: got %0d required 3", key, wa.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wa[i] !== exp_a[i] || wd[i] !== exp_d[i]) begin
                    failures++;
                    $display("FAIL insert_write%0d key=%h: addr=%0d data=%h required addr=%0d data=%h",
                             i, key, wa[i], wd[i], exp_a[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_check_hit;
        int lat;
        logic m, e;
        do_op(OP_CHECK, 32'h12345678, lat, m, e);
        checks++;
        if (lat !== 7 || m !== 1'b1 || e !== 1'b0) begin
            failures++;
            $display("FAIL check_hit: latency=%0d match=%b err=%b required 7/1/0", lat, m, e);
        end
    endtask

    task automatic test_backpressure;
        int lat;
        @(negedge clk);
        wa.delete();
        wd.delete();
        bus.req_valid = 1'b1;
        bus.req_op    = OP_CHECK;
        bus.req_data  = 32'h12345678;
        @(posedge clk); #1;
        bus.req_op = 5'b11111;  // stays valid: must wait for the handshake
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 7) begin
            failures++;
            $display("FAIL bp_latency: got %0d required 7", lat);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_match !== 1'b1 || bus.rsp_err !== 1'b0 ||
                bus.req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d: valid=%b match=%b err=%b ready=%b required 1/1/0/0",
                         c, bus.rsp_valid, bus.rsp_match, bus.rsp_err, bus.req_ready);
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || wa.size() != 0) begin
            failures++;
            $display("FAIL bp_release: valid=%b ready=%b writes=%0d required 0/1/0",
                     bus.rsp_valid, bus.req_ready, wa.size());
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_match !== 1'b0) begin
            failures++;
            $display("FAIL bp_next_op: valid=%b err=%b match=%b required 1/1/0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_match);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_clear;
        int lat;
        logic m, e;
        do_op(OP_CLEAR, 32'h0, lat, m, e);
        checks++;
        if (lat !== 9 || m !== 1'b0 || e !== 1'b0) begin
            failures++;
            $display("FAIL clear_result: latency=%0d match=%b err=%b required 9/0/0", lat, m, e);
        end
        checks++;
        if (ins_count !== 16'd0) begin
            failures++;
            $display("FAIL clear_count: got %0d required 0", ins_count);
        end
        checks++;
        if (wa.size() != 8) begin
            failures++;
            $display("FAIL clear_nwrites: got %0d required 8", wa.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wa[i] !== 3'(i) || wd[i] !== 32'd0) begin
                    failures++;
                    $display("FAIL clear_write%0d: addr=%0d data=%h required addr=%0d data=0",
                             i, wa[i], wd[i], i);
                end
            end
        end
    endtask

    task automatic test_reset_mid_op;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_INSERT;
        bus.req_data  = 32'h12345678;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 3'd0) begin
            failures++;
            $display("FAIL midreset_in_wr: we=%b addr=%0d required 1/0", mem_we, mem_addr);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (mem_we !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 ||
            ins_count !== 16'd0) begin
            failures++;
            $display("FAIL midreset_abort: we=%b valid=%b ready=%b cnt=%0d required 0/0/1/0",
                     mem_we, bus.rsp_valid, bus.req_ready, ins_count);
        end
    endtask

    task automatic test_illegal;
        int lat;
        logic m, e;
        do_op(5'b11111, 32'h12345678, lat, m, e);
        checks++;
        if (lat !== 1 || e !== 1'b1 || m !== 1'b0) begin
            failures++;
            $display("FAIL illegal_result: latency=%0d err=%b match=%b required 1/1/0", lat, e, m);
        end
        checks++;
        if (wa.size() != 0) begin
            failures++;
            $display("FAIL illegal_writes: got %0d required 0", wa.size());
        end
    endtask

    initial begin
        logic [31:0] d1 [3];
        logic [31:0] d2 [3];
        // Key 0x12345678 -> word0 bit8, word2 bit18, word5 bit13.
        d1 = '{32'h0000_0100, 32'h0004_0000, 32'h0000_2000};
        // Key 0 -> word0 bit0, word2 bit26, word5 bit5, merged with the bits above.
        d2 = '{32'h0000_0101, 32'h0404_0000, 32'h0000_2020};
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_check_miss("check_empty");
        test_insert(32'h12345678, d1, 16'd1);
        test_check_hit();
        test_insert(32'h00000000, d2, 16'd2);
        test_backpressure();
        test_clear();
        test_check_miss("check_after_clear");
        test_reset_mid_op();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
